// File: rtl/csa_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-skip adder.
package csa_pipe_pkg;

    localparam int MIN_BLK = 2;

    // Control half of a stage record; the operand/sum slices sit beside it because their width is a module parameter.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
        logic ovf;
    } stage_t;

    function automatic int nblk(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic int nstg(input int width, input int blk, input int bps);
        return width / (blk * bps);
    endfunction

    function automatic bit params_ok(input int width, input int blk, input int bps);
        return (blk >= MIN_BLK) && (bps >= 1) && (width > 0) && ((width % (blk * bps)) == 0);
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One BLK-bit ripple block with a carry-skip bypass driven by the XOR block propagate.
module csa_skip_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a_i,
    input  logic [BLK-1:0] b_i,
    input  logic           cin_i,
    output logic [BLK-1:0] sum_o,
    output logic           cout_o,
    output logic           p_o
);
    logic [BLK-1:0] prop;
    logic [BLK:0]   rip;

    always_comb begin
        prop   = a_i ^ b_i;
        rip    = '0;
        rip[0] = cin_i;
        for (int i = 0; i < BLK; i++) begin
            rip[i+1] = (a_i[i] & b_i[i]) | (prop[i] & rip[i]);
        end
    end

    assign sum_o = prop ^ rip[BLK-1:0];
    assign p_o   = &prop;

    // With an OR propagate a generating bit pair would wrongly let cin bypass the block.
    assign cout_o = p_o ? cin_i : rip[BLK];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder/subtractor: one register stage per S-bit slice, valid/ready with a global stall.
module csa_pipe_adder
    import csa_pipe_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int BLK          = 4,
    parameter int BLKS_PER_STG = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int S    = BLK * BLKS_PER_STG;
    localparam int NBLK = nblk(WIDTH, BLK);
    localparam int NSTG = nstg(WIDTH, BLK, BLKS_PER_STG);

    if (!params_ok(WIDTH, BLK, BLKS_PER_STG) || (NSTG * BLKS_PER_STG != NBLK)) begin : g_bad_params
        $error("csa_pipe_adder: WIDTH must be a multiple of BLK*BLKS_PER_STG and BLK must be >= 2");
    end

    // acc_q starts as operand A and has its low slices overwritten by sum bits as it moves down the pipe.
    stage_t           stg_q [NSTG];
    logic [WIDTH-1:0] acc_q [NSTG];
    logic [WIDTH-1:0] opb_q [NSTG];
    logic             adv;

    assign adv         = !stg_q[NSTG-1].valid | out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = stg_q[NSTG-1].valid;
    assign sum_o       = acc_q[NSTG-1];
    assign cout_o      = stg_q[NSTG-1].carry;
    assign ovf_o       = stg_q[NSTG-1].ovf;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic                    vld_in;
        logic                    cry_in;
        logic                    sub_in;
        logic [WIDTH-1:0]        acc_in;
        logic [WIDTH-1:0]        opb_in;
        logic [WIDTH-1:0]        acc_d;
        stage_t                  stg_d;
        logic [S-1:0]            slice_sum;
        logic [BLKS_PER_STG-1:0] blk_p;
        logic                    top_cin;

        if (k == 0) begin : g_head
            assign vld_in = in_valid_i;
            assign cry_in = sub_i | cin_i;
            assign sub_in = sub_i;
            assign acc_in = a_i;
            assign opb_in = sub_i ? ~b_i : b_i;
        end else begin : g_body
            assign vld_in = stg_q[k-1].valid;
            assign cry_in = stg_q[k-1].carry;
            assign sub_in = stg_q[k-1].sub;
            assign acc_in = acc_q[k-1];
            assign opb_in = opb_q[k-1];
        end

        for (genvar j = 0; j < BLKS_PER_STG; j++) begin : g_blk
            logic c_in;
            logic c_out;

            if (j == 0) begin : g_first
                assign c_in = cry_in;
            end else begin : g_next
                assign c_in = g_blk[j-1].c_out;
            end

            csa_skip_block #(.BLK(BLK)) u_blk (
                .a_i   (acc_in[k*S + j*BLK +: BLK]),
                .b_i   (opb_in[k*S + j*BLK +: BLK]),
                .cin_i (c_in),
                .sum_o (slice_sum[j*BLK +: BLK]),
                .cout_o(c_out),
                .p_o   (blk_p[j])
            );
        end

        // Carry into the slice's top bit recovered from its sum and propagate; only the last stage's ovf is observed.
        assign top_cin = acc_in[k*S + S - 1] ^ opb_in[k*S + S - 1] ^ slice_sum[S-1];

        always_comb begin
            acc_d           = acc_in;
            acc_d[k*S +: S] = slice_sum;
            stg_d           = '0;
            stg_d.valid     = vld_in;
            stg_d.carry     = (&blk_p) ? cry_in : g_blk[BLKS_PER_STG-1].c_out;
            stg_d.sub       = sub_in;
            stg_d.ovf       = top_cin ^ stg_d.carry;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stg_q[k] <= '0;
                acc_q[k] <= '0;
                opb_q[k] <= '0;
            end else if (adv) begin
                stg_q[k] <= stg_d;
                acc_q[k] <= acc_d;
                opb_q[k] <= opb_in;
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed corner cases, random streaming, backpressure and mid-flight reset vs. an arithmetic model.
module tb_csa_pipe_adder;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checkCount = 0;
    int errorCount = 0;
    int pushCount  = 0;
    int popCount   = 0;
    logic [W+1:0] expQ [$];

    csa_pipe_adder #(.WIDTH(W), .BLK(4), .BLKS_PER_STG(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .cin_i      (cin),
        .sub_i      (sub),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum),
        .cout_o     (cout),
        .ovf_o      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                              input logic c, input logic s);
        longint modulus, ua, ub, full, sa, sb, r;
        logic   ov;
        modulus = longint'(1) << W;
        ua      = longint'(av);
        ub      = s ? (modulus - 1 - longint'(bv)) : longint'(bv);
        full    = ua + ub + (s ? longint'(1) : longint'(c));
        sa      = longint'(av) - (av[W-1] ? modulus : 0);
        sb      = longint'(bv) - (bv[W-1] ? modulus : 0);
        r       = s ? (sa - sb) : (sa + sb + longint'(c));
        ov      = (r > (modulus / 2) - 1) || (r < -(modulus / 2));
        return {ov, full[W], full[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: compares every valid output against the oldest outstanding expectation, held or not.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("sum",  32'(sum),  32'(expQ[0][W-1:0]));
                    checkOutput("cout", 32'(cout), 32'(expQ[0][W]));
                    checkOutput("ovf",  32'(ovf),  32'(expQ[0][W+1]));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        popCount++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(a, b, cin, sub));
                pushCount++;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s);
        bit accepted = 1'b0;
        a        = av;
        b        = bv;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendAndTime(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s,
                               input string tag, input logic [W-1:0] expSum, input logic expCout, input logic expOvf);
        int lat = 0;
        applyStimulus(av, bv, c, s);
        in_valid = 1'b0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                checkOutput({tag, "_sum"},  32'(sum),  32'(expSum));
                checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
                checkOutput({tag, "_ovf"},  32'(ovf),  32'(expOvf));
            end
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk);
            #1;
            done = (expQ.size() == 0) && !out_valid;
        end
        checkOutput("drain_outstanding", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int pushBase;
        int popBase;

        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h4321;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        sendAndTime(16'hFFFF, 16'h0000, 1'b1, 1'b0, "full_skip", 16'h0000, 1'b1, 1'b0);
        drain();
        sendAndTime(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf", 16'h7FFF, 1'b1, 1'b1);
        drain();
        sendAndTime(16'h0003, 16'h0005, 1'b1, 1'b1, "sub_borrow", 16'hFFFE, 1'b0, 1'b0);
        drain();
        sendAndTime(16'h7FFF, 16'h0000, 1'b1, 1'b0, "add_ovf", 16'h8000, 1'b0, 1'b1);
        drain();

        $display("[TB] streaming 1000 pairs");
        for (int i = 0; i < 1000; i++) begin
            if (i >= LAT) checkOutput("stream_out_valid", 32'(out_valid), 32'd1);
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        drain();

        $display("[TB] backpressure");
        pushBase  = pushCount;
        popBase   = popCount;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 6; c++) begin
                    @(negedge clk);
                    if (c >= 5) begin
                        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
                        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("bp_accepted", 32'(pushCount - pushBase), 32'd8);
        checkOutput("bp_delivered", 32'(popCount - popBase), 32'd8);

        $display("[TB] mid-flight reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checkOutput("rst_drop_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        sendAndTime(16'h1234, 16'h0FF0, 1'b0, 1'b0, "post_rst", 16'h2224, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
